dm_cache_ctrl: RTL



---
 rtl/dm_cache_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one 32-bit word per line.
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt lookup counters.
module dm_cache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        tag_w_en,
    output logic [9:0]  tag_addr,
    output logic [20:0] tag_data_in,
    input  logic [20:0] tag_data_o,
    output logic        dat_w_en,
    output logic [9:0]  dat_addr,
    output logic [31:0] dat_wdata,
    input  logic [31:0] dat_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_CMP, S_MRD, S_FILL, S_MWR, S_WDONE} state_t;

    state_t      state_q, state_d;
    logic        req_we_q;
    logic [31:2] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [31:0] line_q;
    logic        accept;
    logic        hit;
    logic        unused_addr_bits;

    // The byte offset never affects a word-per-line cache.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign accept = cpu_valid && cpu_ready;
    assign hit    = tag_data_o[20] && (tag_data_o[19:0] == req_addr_q[31:12]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            line_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_we_q    <= cpu_we;
                req_addr_q  <= cpu_addr[31:2];
                req_wdata_q <= cpu_wdata;
            end
            if (state_q == S_MRD && mem_ack) begin
                line_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = '0;
        tag_w_en       = 1'b0;
        dat_w_en       = 1'b0;
        dat_wdata      = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpu_ready = !rst;
                if (cpu_valid && !rst) state_d = S_CMP;
            end
            S_CMP: begin
                if (req_we_q) begin
                    // Store hits update the line in place; misses leave the RAMs untouched.
                    dat_w_en  = hit;
                    dat_wdata = req_wdata_q;
                    state_d   = S_MWR;
                end else if (hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_rdata      = dat_rdata;
                    state_d        = S_IDLE;
                end else begin
                    state_d = S_MRD;
                end
            end
            S_MRD: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                tag_w_en       = 1'b1;
                dat_w_en       = 1'b1;
                dat_wdata      = line_q;
                cpu_resp_valid = 1'b1;
                cpu_rdata      = line_q;
                state_d        = S_IDLE;
            end
            S_MWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_d = S_WDONE;
            end
            S_WDONE: begin
                cpu_resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tag_addr    = req_addr_q[11:2];
    assign dat_addr    = req_addr_q[11:2];
    assign tag_data_in = {1'b1, req_addr_q[31:12]};
    assign mem_addr    = {req_addr_q, 2'b00};
    assign mem_wdata   = req_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_CMP) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule
